// File: rtl/stream_byte_swapper_pkg.sv
// Shared types and byte-permutation helpers for the stream byte swapper.
// Lane swaps are an index XOR, so one function covers every lane size.
package stream_byte_swapper_pkg;

  localparam int unsigned MAX_BYTES = 64;
  localparam int unsigned MAX_W     = 8 * MAX_BYTES;

  typedef enum logic [2:0] {
    PASS    = 3'd0,
    SWAP16  = 3'd1,
    SWAP32  = 3'd2,
    SWAP64  = 3'd3,
    REVERSE = 3'd4
  } swap_mode_t;

  // Lane size in bytes for a mode; 0 marks an unknown encoding.
  function automatic int unsigned lane_bytes(
    input logic [2:0]  mode,
    input int unsigned n_bytes
  );
    case (mode)
      PASS:    return 1;
      SWAP16:  return 2;
      SWAP32:  return 4;
      SWAP64:  return 8;
      REVERSE: return n_bytes;
      default: return 0;
    endcase
  endfunction

  function automatic logic [MAX_W-1:0] swap_bytes(
    input logic [MAX_W-1:0] data,
    input int unsigned      lane,
    input int unsigned      n_bytes
  );
    logic [MAX_W-1:0] r;
    int unsigned      src;
    r = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      src = (i ^ (lane - 1)) & (MAX_BYTES - 1);
      if (i < n_bytes)
        r[8*i +: 8] = data[8*src +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready buffer with a registered input ready.
// Output register plus one skid slot absorbs the beat in flight on a stall.
module stream_skid_buffer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              load;
  logic              in_fire;

  assign load    = !out_valid || out_ready;
  assign in_fire = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else if (load) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire)
          out_data <= in_data;
      end
      in_ready <= 1'b1;
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      in_ready   <= 1'b0;
    end else begin
      in_ready <= !skid_valid;
    end
  end

endmodule

// File: rtl/stream_byte_swapper.sv
// Registered per-packet byte-order converter for valid/ready streams.
// Mode is latched on a packet's first beat; illegal modes pass data through.
module stream_byte_swapper
  import stream_byte_swapper_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic [DATA_BYTES-1:0]   s_keep,
  input  logic                    s_last,
  input  logic [2:0]              s_mode,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [8*DATA_BYTES-1:0] m_data,
  output logic [DATA_BYTES-1:0]   m_keep,
  output logic                    m_last,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned BW = DW + DATA_BYTES + 1;

  logic                  fire;
  logic                  in_pkt;
  logic [2:0]            held_mode;
  logic [2:0]            cur_mode;
  int unsigned           lane_raw;
  int unsigned           lane;
  logic                  legal;
  logic [DW-1:0]         data_sw;
  logic [DW-1:0]         keep_wide;
  logic [DW-1:0]         keep_wide_sw;
  logic [DATA_BYTES-1:0] keep_sw;

  assign fire     = s_valid && s_ready;
  assign cur_mode = in_pkt ? held_mode : s_mode;

  always_comb begin
    lane_raw = lane_bytes(cur_mode, DATA_BYTES);
    legal    = (lane_raw != 0) && (lane_raw <= DATA_BYTES);
    lane     = legal ? lane_raw : 1;
  end

  // Keep rides the byte permutation as one replicated byte per lane slot.
  for (genvar g = 0; g < DATA_BYTES; g++) begin : g_keep
    assign keep_wide[8*g +: 8] = {8{s_keep[g]}};
    assign keep_sw[g]          = |keep_wide_sw[8*g +: 8];
  end

  assign data_sw      = DW'(swap_bytes(MAX_W'(s_data), lane, DATA_BYTES));
  assign keep_wide_sw = DW'(swap_bytes(MAX_W'(keep_wide), lane, DATA_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt    <= 1'b0;
      held_mode <= PASS;
      err_cnt   <= '0;
    end else if (fire) begin
      if (!in_pkt)
        held_mode <= s_mode;
      in_pkt <= !s_last;
      if (!in_pkt && !legal && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
    end
  end

  stream_skid_buffer #(
    .DATA_W(BW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s_valid),
    .in_ready (s_ready),
    .in_data  ({data_sw, keep_sw, s_last}),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data ({m_data, m_keep, m_last})
  );

endmodule

// File: tb/tb_stream_byte_swapper.sv
// Bench for stream_byte_swapper: vector table, packet sequences and a
// random-backpressure scoreboard run, plus a 4-byte instance.
module tb_stream_byte_swapper;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    logic [2:0]  mode;
    logic [63:0] d;
    logic [7:0]  k;
    logic [63:0] ed;
    logic [7:0]  ek;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic [7:0]  s_keep = '0;
  logic        s_last = 1'b0;
  logic [2:0]  s_mode = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [63:0] m_data;
  logic [7:0]  m_keep;
  logic        m_last;
  logic [15:0] err_cnt;

  logic        s4_valid = 1'b0;
  logic        s4_ready;
  logic [31:0] s4_data = '0;
  logic [3:0]  s4_keep = '0;
  logic        s4_last = 1'b0;
  logic [2:0]  s4_mode = '0;
  logic        m4_valid;
  logic [31:0] m4_data;
  logic [3:0]  m4_keep;
  logic        m4_last;
  logic [15:0] err4;

  int    total = 0;
  int    bad = 0;
  int    ready_mode = 0;
  int    err_exp = 0;
  beat_t sbq[$];
  vec_t  tv[8];

  always #5 clk = ~clk;

  stream_byte_swapper #(.DATA_BYTES(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_keep(s_keep), .s_last(s_last), .s_mode(s_mode),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_keep(m_keep), .m_last(m_last), .err_cnt(err_cnt)
  );

  stream_byte_swapper #(.DATA_BYTES(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s4_valid), .s_ready(s4_ready), .s_data(s4_data),
    .s_keep(s4_keep), .s_last(s4_last), .s_mode(s4_mode),
    .m_valid(m4_valid), .m_ready(1'b1), .m_data(m4_data),
    .m_keep(m4_keep), .m_last(m4_last), .err_cnt(err4)
  );

  function automatic int model_lane(input logic [2:0] mode);
    case (mode)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd3: return 8;
      3'd4: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_illegal(input logic [2:0] mode);
    return model_lane(mode) == 0;
  endfunction

  function automatic int eff_lane(input logic [2:0] mode);
    return model_illegal(mode) ? 1 : model_lane(mode);
  endfunction

  function automatic logic [63:0] model_swap(
    input logic [63:0] d, input logic [2:0] mode);
    logic [63:0] r;
    int ln, j;
    ln = eff_lane(mode);
    for (int i = 0; i < 8; i++) begin
      j = (i / ln) * ln + (ln - 1 - i % ln);
      r[8*i +: 8] = d[8*j +: 8];
    end
    return r;
  endfunction

  function automatic logic [7:0] model_keep(
    input logic [7:0] k, input logic [2:0] mode);
    logic [7:0] r;
    int ln, j;
    ln = eff_lane(mode);
    for (int i = 0; i < 8; i++) begin
      j = (i / ln) * ln + (ln - 1 - i % ln);
      r[i] = k[j];
    end
    return r;
  endfunction

  task automatic check(input string name,
                       input logic [79:0] act,
                       input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    bit          prev_stall = 0;
    logic [72:0] prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check("stall_hold", {m_valid, m_data, m_keep, m_last},
                {1'b1, prev});
        if (m_valid && m_ready) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got %h with empty queue",
                     m_data);
          end else begin
            beat_t e;
            e = sbq.pop_front();
            check("out_data", m_data, e.d);
            check("out_keep", m_keep, e.k);
            check("out_last", m_last, e.l);
          end
        end
        prev_stall = m_valid && !m_ready;
        prev = {m_data, m_keep, m_last};
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k,
                      input logic l, input logic [2:0] md,
                      input beat_t e);
    int w = 0;
    s_data = d;
    s_keep = k;
    s_last = l;
    s_mode = md;
    s_valid = 1'b1;
    while (!s_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: s_ready=0 after %0d cycles, want 1", w);
      s_valid = 1'b0;
    end else begin
      sbq.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic send_pkt(input int len, input logic [2:0] md);
    beat_t       e;
    logic [63:0] d;
    logic [7:0]  k;
    logic [2:0]  mi;
    if (model_illegal(md))
      err_exp++;
    for (int b = 0; b < len; b++) begin
      d = {$urandom, $urandom};
      k = 8'($urandom);
      mi = (b == 0) ? md : 3'($urandom);
      e.d = model_swap(d, md);
      e.k = model_keep(k, md);
      e.l = (b == len - 1);
      send(d, k, b == len - 1, mi, e);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain_left", sbq.size(), 0);
  endtask

  initial begin
    beat_t   e;
    int      w;
    int      beats;
    longint  t0, t1;

    tv[0] = '{3'd1, 64'h0011223344556677, 8'hFF, 64'h1100332255447766, 8'hFF};
    tv[1] = '{3'd2, 64'h0011223344556677, 8'hFF, 64'h3322110077665544, 8'hFF};
    tv[2] = '{3'd4, 64'h0011223344556677, 8'h0F, 64'h7766554433221100, 8'hF0};
    tv[3] = '{3'd0, 64'h0123456789ABCDEF, 8'h5A, 64'h0123456789ABCDEF, 8'h5A};
    tv[4] = '{3'd3, 64'h0011223344556677, 8'h01, 64'h7766554433221100, 8'h80};
    tv[5] = '{3'd1, 64'h0123456789ABCDEF, 8'h05, 64'h23016745AB89EFCD, 8'h0A};
    tv[6] = '{3'd5, 64'h0123456789ABCDEF, 8'h0F, 64'h0123456789ABCDEF, 8'h0F};
    tv[7] = '{3'd7, 64'h0011223344556677, 8'h3C, 64'h0011223344556677, 8'h3C};

    fork
      monitor();
      ready_drv();
      begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_keep", m_keep, 0);
    check("rst_m_last", m_last, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", s_ready, 1);

    // 4-byte instance: SWAP64 and mode 6 are both illegal there
    s4_mode = 3'd3;
    s4_data = 32'h11223344;
    s4_keep = 4'hF;
    s4_last = 1'b1;
    s4_valid = 1'b1;
    w = 0;
    while (!s4_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    s4_mode = 3'd6;
    s4_data = 32'hA1B2C3D4;
    s4_keep = 4'h3;
    check("n4_valid0", m4_valid, 1);
    check("n4_data0", m4_data, 32'h11223344);
    @(negedge clk);
    s4_valid = 1'b0;
    check("n4_data1", m4_data, 32'hA1B2C3D4);
    check("n4_keep1", m4_keep, 4'h3);
    check("n4_err", err4, 2);

    for (int i = 0; i < 8; i++) begin
      e.d = tv[i].ed;
      e.k = tv[i].ek;
      e.l = 1'b1;
      if (model_illegal(tv[i].mode))
        err_exp++;
      send(tv[i].d, tv[i].k, 1'b1, tv[i].mode, e);
      s_valid = 1'b0;
      check("latency_1clk", m_valid, 1);
      @(negedge clk);
    end
    check("err_after_table", err_cnt, err_exp);

    send(64'h0011223344556677, 8'hFF, 1'b0, 3'd2,
         '{64'h3322110077665544, 8'hFF, 1'b0});
    send(64'h8899AABBCCDDEEFF, 8'hFF, 1'b0, 3'd0,
         '{64'hBBAA9988FFEEDDCC, 8'hFF, 1'b0});
    send(64'h0102030405060708, 8'h03, 1'b1, 3'd0,
         '{64'h0403020108070605, 8'h0C, 1'b1});
    s_valid = 1'b0;
    drain();

    ready_mode = 1;
    beats = 0;
    while (beats < 1000) begin
      w = $urandom_range(1, 6);
      send_pkt(w, 3'($urandom_range(0, 7)));
      beats += w;
    end
    s_valid = 1'b0;
    ready_mode = 0;
    drain();
    check("err_after_random", err_cnt, err_exp);

    repeat (3) @(negedge clk);
    t0 = $time;
    send_pkt(20, 3'd1);
    t1 = $time;
    s_valid = 1'b0;
    check("throughput_cycles", (t1 - t0) / 10, 20);
    drain();

    ready_mode = 2;
    repeat (3) @(negedge clk);
    e.d = model_swap(64'h0011223344556677, 3'd1);
    e.k = 8'hFF;
    e.l = 1'b0;
    send(64'h0011223344556677, 8'hFF, 1'b0, 3'd1, e);
    e.d = model_swap(64'h8899AABBCCDDEEFF, 3'd1);
    send(64'h8899AABBCCDDEEFF, 8'hFF, 1'b0, 3'd1, e);
    s_valid = 1'b0;
    check("skid_full_ready", s_ready, 0);
    check("skid_full_valid", m_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", m_valid, 0);
    check("async_rst_err", err_cnt, 0);
    check("async_rst_ready", s_ready, 0);
    sbq.delete();
    err_exp = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    @(negedge clk);
    send(64'h0011223344556677, 8'hFF, 1'b1, 3'd2,
         '{64'h3322110077665544, 8'hFF, 1'b1});
    s_valid = 1'b0;
    drain();
    check("err_after_reset", err_cnt, err_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
